// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - 8-digit seven-segment scan controller
// Holds a 32-bit hex value, scans one nibble per slot, commits new values only at frame ends.
module display_scan_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = $clog2(REFRESH_DIV) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        lz_blank_en,
  output logic [3:0]  input_bits,
  output logic [2:0]  select,
  output logic        digit_blank,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] prescaler;
  logic [2:0]       scan_idx;
  logic [31:0]      disp_reg;
  logic [31:0]      pend_reg;
  logic             pend_valid;
  logic             frame_start_q;

  logic        tick;
  logic        wrap;
  logic        accept;
  logic        commit;
  logic [31:0] upper_digits;

  assign tick   = (prescaler == LAST_COUNT);
  assign wrap   = tick && (scan_idx == 3'd7);
  assign accept = load_valid && !pend_valid;
  // Commit needs pend_valid=1 and accept needs pend_valid=0, so they never collide.
  assign commit = wrap && pend_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler     <= '0;
      scan_idx      <= 3'd0;
      disp_reg      <= 32'd0;
      pend_reg      <= 32'd0;
      pend_valid    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      prescaler     <= tick ? '0 : prescaler + 1'b1;
      frame_start_q <= wrap;
      if (tick) begin
        scan_idx <= scan_idx + 3'd1;
      end
      if (commit) begin
        disp_reg   <= pend_reg;
        pend_valid <= 1'b0;
      end else if (accept) begin
        pend_reg   <= load_data;
        pend_valid <= 1'b1;
      end
    end
  end

  // Nibbles at and above the scanned digit; all zero means this digit is a leading zero.
  assign upper_digits = disp_reg >> {scan_idx, 2'b00};

  assign load_ready  = !pend_valid;
  assign select      = scan_idx;
  assign input_bits  = disp_reg[{scan_idx, 2'b00} +: 4];
  assign digit_blank = lz_blank_en && (scan_idx != 3'd0) && (upper_digits == 32'd0);
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - checks two scan controllers (REFRESH_DIV 4 and 1)
// against a cycle-count model of scan position, pending value and displayed value.
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [31:0] load_data;
  logic        lz_blank_en;

  logic        ready_a, blank_a, fs_a;
  logic [3:0]  bits_a;
  logic [2:0]  sel_a;
  logic        ready_b, blank_b, fs_b;
  logic [3:0]  bits_b;
  logic [2:0]  sel_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  display_scan_controller #(.REFRESH_DIV(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready_a),
    .load_data(load_data), .lz_blank_en(lz_blank_en), .input_bits(bits_a),
    .select(sel_a), .digit_blank(blank_a), .frame_start(fs_a)
  );

  display_scan_controller #(.REFRESH_DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready_b),
    .load_data(load_data), .lz_blank_en(lz_blank_en), .input_bits(bits_b),
    .select(sel_b), .digit_blank(blank_b), .frame_start(fs_b)
  );

  // Model: t counts cycles since reset; scan position follows from t alone.
  int          div_m [2] = '{4, 1};
  int          t_m   [2];
  logic [31:0] disp_m [2];
  logic [31:0] pend_m [2];
  logic        pendv_m [2];
  logic        armed = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        t_m[k] = 0; disp_m[k] = 0; pend_m[k] = 0; pendv_m[k] = 0;
      end else begin
        if (((t_m[k] + 1) % (8 * div_m[k])) == 0 && pendv_m[k]) begin
          disp_m[k] = pend_m[k];
          pendv_m[k] = 1'b0;
        end else if (load_valid && !pendv_m[k]) begin
          pend_m[k] = load_data;
          pendv_m[k] = 1'b1;
        end
        t_m[k] = t_m[k] + 1;
      end
    end
    if (!rst_n) armed = 1'b1;
  end

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int k, input logic [2:0] sel, input logic [3:0] bits,
                            input logic blank, input logic ready, input logic fs);
    int    s;
    int    upper;
    string tag;
    tag   = (k == 0) ? "div4" : "div1";
    s     = (t_m[k] / div_m[k]) % 8;
    upper = int'(disp_m[k] >> (4 * s));
    cmp({tag, ".select"}, sel, s);
    cmp({tag, ".input_bits"}, bits, upper & 4'hF);
    cmp({tag, ".digit_blank"}, blank, (lz_blank_en && s != 0 && upper == 0) ? 1 : 0);
    cmp({tag, ".load_ready"}, ready, pendv_m[k] ? 0 : 1);
    cmp({tag, ".frame_start"}, fs, (t_m[k] != 0 && t_m[k] % (8 * div_m[k]) == 0) ? 1 : 0);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check_inst(0, sel_a, bits_a, blank_a, ready_a, fs_a);
      check_inst(1, sel_b, bits_b, blank_b, ready_b, fs_b);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = 32'h0; lz_blank_en = 1'b0;
    step(2);
    rst_n = 1'b1;
    cmp("reset.select", sel_a, 0);
    cmp("reset.input_bits", bits_a, 0);
    cmp("reset.digit_blank", blank_a, 0);
    cmp("reset.load_ready", ready_a, 1);
    cmp("reset.frame_start", fs_a, 0);
    step(31);
    cmp("t31.frame_start", fs_a, 0);
    step(1);
    cmp("t32.frame_start", fs_a, 1);
    cmp("t32.select", sel_a, 0);
    cmp("t32.div1.frame_start", fs_b, 1);
    step(12);
    cmp("t44.select", sel_a, 3);
    load_valid = 1'b1; load_data = 32'h1234_5678;
    step(1);
    load_data = 32'hDEAD_BEEF;
    load_valid = 1'b0;
    cmp("accept.load_ready", ready_a, 0);
    cmp("pre_commit.input_bits", bits_a, 0);
    load_valid = 1'b1; load_data = 32'hCAFE_F00D;
    step(19);
    cmp("commit.select", sel_a, 0);
    cmp("commit.input_bits", bits_a, 4'h8);
    cmp("commit.load_ready", ready_a, 1);
    cmp("commit.frame_start", fs_a, 1);
    step(1);
    load_valid = 1'b0; load_data = 32'h0;
    cmp("second_accept.load_ready", ready_a, 0);
    step(27);
    cmp("t92.select", sel_a, 7);
    cmp("t92.input_bits", bits_a, 4'h1);
    step(36);
    cmp("t128.input_bits", bits_a, 4'hD);
    step(4);
    cmp("t132.input_bits", bits_a, 4'h0);
    lz_blank_en = 1'b1;
    load_valid = 1'b1; load_data = 32'h0000_00A5;
    step(1);
    load_valid = 1'b0;
    step(27);
    cmp("a5.sel0.input_bits", bits_a, 4'h5);
    cmp("a5.sel0.blank", blank_a, 0);
    step(4);
    cmp("a5.sel1.input_bits", bits_a, 4'hA);
    cmp("a5.sel1.blank", blank_a, 0);
    step(4);
    cmp("a5.sel2.blank", blank_a, 1);
    load_valid = 1'b1; load_data = 32'h0;
    step(1);
    load_valid = 1'b0;
    step(23);
    cmp("zero.sel0.blank", blank_a, 0);
    step(4);
    cmp("zero.sel1.blank", blank_a, 1);
    load_valid = 1'b1; load_data = 32'h1111_1111;
    step(1);
    load_valid = 1'b0;
    step(15);
    cmp("pre_reset.select", sel_a, 5);
    cmp("pre_reset.load_ready", ready_a, 0);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1; lz_blank_en = 1'b0;
    cmp("midreset.select", sel_a, 0);
    cmp("midreset.input_bits", bits_a, 0);
    cmp("midreset.load_ready", ready_a, 1);
    cmp("midreset.frame_start", fs_a, 0);
    step(3);
    cmp("div1.t3.select", sel_b, 3);
    load_valid = 1'b1; load_data = 32'h8765_4321;
    step(1);
    load_valid = 1'b0;
    cmp("div1.accept.load_ready", ready_b, 0);
    step(3);
    cmp("div1.t7.select", sel_b, 7);
    cmp("div1.t7.input_bits", bits_b, 0);
    step(1);
    cmp("div1.t8.frame_start", fs_b, 1);
    cmp("div1.t8.select", sel_b, 0);
    cmp("div1.t8.input_bits", bits_b, 4'h1);
    cmp("div1.t8.load_ready", ready_b, 1);
    step(7);
    cmp("div1.t15.input_bits", bits_b, 4'h8);
    step(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexed scan controller for the 8-digit seven-segment display; sits directly upstream of the seven-segment decoder.
- Holds a 32-bit hex value as eight 4-bit digits and cycles the digit index at a programmable refresh rate.
- Per scan slot, presents that digit's nibble and index, which drive the decoder's input_bits and select inputs.
- Accepts new display values through a valid/ready handshake and commits them only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz clk gives 1 kHz per digit, 125 Hz per frame); legal range 1 to 2^24.
- CNT_W, $clog2(REFRESH_DIV)+1, prescaler width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a load this cycle.
- load_data  input  32  new display value; [3:0] is digit 0 (rightmost, S1), [31:28] is digit 7 (leftmost, S8).
- lz_blank_en  input  1  enable leading-zero blanking.
- input_bits  output  4  nibble of the currently scanned digit, to the decoder.
- select  output  3  currently scanned digit index 0..7, to the decoder.
- digit_blank  output  1  the current digit must be blanked (the board forces its anode off).
- frame_start  output  1  one-cycle pulse on the first cycle of each frame (select returns to 0).

Behaviour:
- State:
  - prescaler (CNT_W bits)
  - scan_idx (3 bits)
  - disp_reg (32 bits)
  - pend_reg (32 bits)
  - pend_valid (1 bit)
  - frame_start register
- Reset (rst_n=0 at a clock edge):
  - prescaler=0, scan_idx=0, disp_reg=0, pend_reg=0, pend_valid=0, frame_start=0.
  - Outputs after the edge: select=0, input_bits=0, digit_blank=0, load_ready=1.
  - Loads are ignored while rst_n=0.
  - Reset mid-frame or mid-handshake discards any pending value; no partial state survives.
- Prescaler:
  - Increments every cycle.
  - tick=1 when prescaler==REFRESH_DIV-1; on tick, prescaler returns to 0.
  - REFRESH_DIV=1 gives tick every cycle.
- Scan: on tick, scan_idx <= scan_idx+1, wrapping 7 to 0. select = scan_idx (registered, no extra latency).
- Handshake:
  - load_ready = !pend_valid.
  - A transfer occurs when load_valid && load_ready at a clock edge: pend_reg <= load_data, pend_valid <= 1.
  - load_data is not required stable after acceptance.
  - A load_valid held while load_ready=0 stalls and is not captured.
- Frame commit:
  - On tick with scan_idx==7 and pend_valid=1: disp_reg <= pend_reg, pend_valid <= 0.
  - load_ready rises on the following cycle.
  - Commit and acceptance in the same cycle are impossible, because acceptance requires pend_valid=0.
  - A load accepted on the wrap-tick cycle itself goes to pend_reg and commits at the next frame end.
- frame_start is registered: it is 1 for exactly one cycle, the cycle in which scan_idx first reads 0 after a 7-to-0 wrap. It is not asserted out of reset.
- input_bits = disp_reg[4*scan_idx +: 4], combinational from registered state. input_bits and select always change together.
- digit_blank:
  - 1 iff lz_blank_en=1, scan_idx!=0, and every nibble j with scan_idx <= j <= 7 of disp_reg is zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Combinational from registered state and lz_blank_en.
- Dwell: each digit dwells exactly REFRESH_DIV cycles, so a frame lasts 8*REFRESH_DIV cycles. Loads never disturb scan timing.

Test Plan:
- Reset, then REFRESH_DIV=4 with no loads -> select steps 0,1,...,7,0 every 4 cycles; input_bits=0; frame_start pulses once per 32 cycles, first at cycle 32.
- Load 32'h1234_5678 mid-frame (select=3) -> load_ready drops next cycle; digits stay 0 until the wrap; from the frame start, select=0 shows 8, select=7 shows 1; load_ready returns to 1 one cycle after the commit.
- Second load presented while pend_valid=1 -> not accepted (load_ready=0); it is captured the cycle after commit and displayed one frame later.
- lz_blank_en=1 with value 32'h0000_00A5 -> digit_blank=1 for select 2..7 and 0 for select 0,1; value 0 -> only select 0 unblanked.
- Assert rst_n=0 for one cycle at select=5 with a load pending -> next cycle select=0, disp_reg=0, pend_valid=0, load_ready=1, frame_start=0.
- REFRESH_DIV=1 -> select increments every cycle; frame_start pulses every 8 cycles; commit occurs on the 7-to-0 edge.
